// File: rtl/llc_pkg.sv
// Shared types and widths for the LLC port arbiters.
package llc_pkg;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RESP
    } arb_state_t;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping from N-1 back to 0. Works for any N >= 2, power of two or not.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    // Index arithmetic modulo N; base < N and offset < N so one subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned     offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [N-1:0]     rot_req;
    logic [IDX_W-1:0] off;

    // Rotate so that position 0 is the requester currently holding priority.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_req[gi] = req[wrap_add(ptr, gi)];
    end

    // Lowest rotated position with a request wins.
    always_comb begin
        off = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                off = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

    assign gnt_idx = wrap_add(ptr, 32'(off));

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign gnt_onehot[gi] = any & (gnt_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/llc_read_arbiter.sv
// Shares the single LLC read port among NUM_REQ requesters. Each requester owns
// a one-entry address buffer; buffers are served round-robin, one LLC read at a
// time, and the returned line is registered and handed back with a one-cycle
// one-hot resp_valid pulse.
module llc_read_arbiter
    import llc_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [LINE_W-1:0]         resp_data,
    output logic [ADDR_W-1:0]         llc_r_addr,
    output logic                      llc_r_addr_valid,
    input  logic [LINE_W-1:0]         llc_r_data,
    input  logic                      llc_r_data_valid,
    output logic                      err_timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [NUM_REQ-1:0] grant_onehot_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [NUM_REQ-1:0] buf_full_reg;
    addr_t              buf_addr_reg [NUM_REQ];
    logic [NUM_REQ-1:0] resp_valid_reg;
    line_t              resp_data_reg;
    addr_t              llc_r_addr_reg;
    logic               llc_r_addr_valid_reg;
    logic               err_timeout_reg;

    addr_t              req_addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] release_vec;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic               arb_any;
    logic               txn_done;

    // The LLC line only counts while a read is outstanding.
    assign txn_done    = (state_reg == ARB_ISSUE) && llc_r_data_valid;
    assign rr_ptr_next = (grant_reg == IDX_LAST) ? '0 : grant_reg + 1'b1;

    // Per-requester unpacking, handshake and buffer release.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign req_ready[gi]    = ~buf_full_reg[gi];
        assign accept[gi]       = req_valid[gi] & ~buf_full_reg[gi];
        assign release_vec[gi]  = txn_done & grant_onehot_reg[gi];
    end

    // Only registered buffer state feeds the arbiter, so a buffer filled this
    // cycle becomes eligible on the next one.
    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .req       (buf_full_reg),
        .ptr       (rr_ptr_reg),
        .gnt_onehot(arb_onehot),
        .gnt_idx   (arb_idx),
        .any       (arb_any)
    );

    // Request buffers: fill on handshake, empty when the LLC returns the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full_reg <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_addr_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    buf_full_reg[i] <= 1'b1;
                    buf_addr_reg[i] <= req_addr_arr[i];
                end else if (release_vec[i]) begin
                    buf_full_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Transaction FSM with registered LLC request, response and timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= ARB_IDLE;
            grant_reg            <= '0;
            grant_onehot_reg     <= '0;
            rr_ptr_reg           <= '0;
            wait_cnt_reg         <= '0;
            resp_valid_reg       <= '0;
            resp_data_reg        <= '0;
            llc_r_addr_reg       <= '0;
            llc_r_addr_valid_reg <= 1'b0;
            err_timeout_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    resp_valid_reg <= '0;
                    if (arb_any) begin
                        grant_reg            <= arb_idx;
                        grant_onehot_reg     <= arb_onehot;
                        llc_r_addr_reg       <= buf_addr_reg[arb_idx];
                        llc_r_addr_valid_reg <= 1'b1;
                        wait_cnt_reg         <= '0;
                        state_reg            <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // Timeout only flags the condition; the read keeps waiting.
                    if (wait_cnt_reg == CNT_LAST) begin
                        err_timeout_reg <= 1'b1;
                    end
                    if (llc_r_data_valid) begin
                        resp_data_reg        <= llc_r_data;
                        resp_valid_reg       <= grant_onehot_reg;
                        rr_ptr_reg           <= rr_ptr_next;
                        wait_cnt_reg         <= '0;
                        llc_r_addr_valid_reg <= 1'b0;
                        state_reg            <= ARB_RESP;
                    end else if (wait_cnt_reg != CNT_LAST) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ARB_RESP: begin
                    // addr_valid is low here, so the LLC sees a gap before the next read.
                    resp_valid_reg <= '0;
                    state_reg      <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign resp_valid       = resp_valid_reg;
    assign resp_data        = resp_data_reg;
    assign llc_r_addr       = llc_r_addr_reg;
    assign llc_r_addr_valid = llc_r_addr_valid_reg;
    assign err_timeout      = err_timeout_reg;

endmodule

// File: tb/tb_llc_read_arbiter.sv
// Bench for llc_read_arbiter: a behavioural LLC with programmable latency, a
// response scoreboard, table-driven single transactions and hand-written
// sequences for contention, refill, reset and timeout. A second instance with
// a short timeout exercises err_timeout.
module tb_llc_read_arbiter;

    localparam int NR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;

    logic [NR-1:0]    req_valid;
    logic [NR*64-1:0] req_addr;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [511:0]     resp_data;
    logic [63:0]      llc_r_addr;
    logic             llc_r_addr_valid;
    logic [511:0]     llc_r_data;
    logic             llc_r_data_valid;
    logic             err_timeout;

    logic [NR-1:0]    req_valid_b;
    logic [NR*64-1:0] req_addr_b;
    logic [NR-1:0]    req_ready_b;
    logic [NR-1:0]    resp_valid_b;
    logic [511:0]     resp_data_b;
    logic [63:0]      llc_r_addr_b;
    logic             llc_r_addr_valid_b;
    logic [511:0]     llc_r_data_b;
    logic             llc_r_data_valid_b;
    logic             err_timeout_b;

    llc_read_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(1024)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .llc_r_addr      (llc_r_addr),
        .llc_r_addr_valid(llc_r_addr_valid),
        .llc_r_data      (llc_r_data),
        .llc_r_data_valid(llc_r_data_valid),
        .err_timeout     (err_timeout)
    );

    llc_read_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(8)) u_dut_to (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid_b),
        .req_addr        (req_addr_b),
        .req_ready       (req_ready_b),
        .resp_valid      (resp_valid_b),
        .resp_data       (resp_data_b),
        .llc_r_addr      (llc_r_addr_b),
        .llc_r_addr_valid(llc_r_addr_valid_b),
        .llc_r_data      (llc_r_data_b),
        .llc_r_data_valid(llc_r_data_valid_b),
        .err_timeout     (err_timeout_b)
    );

    typedef struct {
        int          req;
        logic [63:0] addr;
        int          lat;    // edges from accept to resp pulse, -1 = not checked
        int          issue;  // cycles llc_r_addr_valid is high for this read
    } exp_t;

    typedef struct {
        int          req;
        logic [63:0] addr;
        int          delay;
        int          lat;
        int          issue;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          edge_cnt     = 0;
    int          acc_edge[NR];
    int          issue_len    = 0;
    int          llc_cnt      = 0;
    int          llc_delay    = 0;
    int          llc_txn      = 0;
    int          unexp_cnt    = 0;
    int          unexp_before;
    logic        addr_moved   = 1'b0;
    logic        llc_spurious = 1'b0;
    logic        refill_pending = 1'b0;
    logic [63:0] refill_addr  = '0;
    logic [63:0] issue_addr   = '0;

    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*64 +: 64] = a ^ (64'h0123_4567_89AB_CDEF + 64'(k) * 64'h1111_0000_1111_0000);
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic issue_req(input int i, input logic [63:0] a);
        req_valid[i]          = 1'b1;
        req_addr[i*64 +: 64]  = a;
    endtask

    // Behavioural LLC: answers the read in ISSUE cycle llc_delay+1.
    task automatic llc_model();
        if (llc_r_addr_valid === 1'b1) begin
            if (llc_cnt == llc_delay) begin
                llc_r_data_valid = 1'b1;
                llc_r_data       = line_of(llc_r_addr);
                llc_cnt          = 0;
                llc_txn++;
            end else begin
                llc_r_data_valid = 1'b0;
                llc_r_data       = {16{$urandom}};
                llc_cnt++;
            end
        end else begin
            llc_r_data_valid = llc_spurious;
            llc_r_data       = {16{$urandom}};
            llc_cnt          = 0;
        end
    endtask

    // Tracks the current LLC read and compares each resp pulse with the scoreboard.
    task automatic monitor();
        exp_t          e;
        logic [NR-1:0] oh;
        if (llc_r_addr_valid === 1'b1) begin
            if (issue_len == 0) begin
                issue_addr = llc_r_addr;
            end else if (llc_r_addr !== issue_addr) begin
                addr_moved = 1'b1;
            end
            issue_len++;
        end
        if (resp_valid !== '0 && resp_valid !== 'x) begin
            if (exp_q.size() == 0) begin
                unexp_cnt++;
                check("unexpected_resp", 512'(resp_valid), 512'(0));
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e.req] = 1'b1;
                $display("[TB] resp req%0d addr %0h edge %0d", e.req, e.addr, edge_cnt);
                check("resp_valid", 512'(resp_valid), 512'(oh));
                check("resp_data", resp_data, line_of(e.addr));
                check("issued_addr", 512'(issue_addr), 512'(e.addr));
                check("addr_held", 512'(addr_moved), 512'(0));
                check("issue_cycles", 512'(issue_len), 512'(e.issue));
                if (e.lat >= 0) begin
                    check("latency", 512'(edge_cnt - acc_edge[e.req]), 512'(e.lat));
                end
            end
            issue_len  = 0;
            addr_moved = 1'b0;
            // Refill in the RESP cycle of requester 0.
            if (resp_valid[0] && refill_pending) begin
                refill_pending = 1'b0;
                issue_req(0, refill_addr);
                exp_q.push_back('{0, refill_addr, -1, llc_delay + 1});
            end
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                acc_edge[i]  = edge_cnt;
                req_valid[i] = 1'b0;
            end
        end
        llc_model();
        monitor();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("resp_within_budget", 512'(exp_q.size()), 512'(0));
        exp_q.delete();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        issue_len      = 0;
        addr_moved     = 1'b0;
        refill_pending = 1'b0;
        req_valid      = '0;
        req_valid_b    = '0;
        exp_q.delete();
    endtask

    initial begin
        // {req, addr, llc delay, accept->resp edges, addr_valid cycles}
        vecs[0] = '{0, 64'h0000_0000_0000_1000, 0, 2, 1};
        vecs[1] = '{0, 64'h0000_0000_0000_1000, 20, 22, 21};
        vecs[2] = '{1, 64'h0000_00DE_ADBE_EF00, 0, 2, 1};
        vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFC0, 5, 7, 6};
        vecs[4] = '{0, 64'h0000_0000_0000_0000, 1, 3, 2};

        reset              = 1'b1;
        req_valid          = '0;
        req_addr           = '0;
        req_valid_b        = '0;
        req_addr_b         = '0;
        llc_r_data         = '0;
        llc_r_data_valid   = 1'b0;
        llc_r_data_b       = '0;
        llc_r_data_valid_b = 1'b0;
        acc_edge           = '{0, 0};

        repeat (3) tick();
        reset = 1'b0;

        check("rst_req_ready", 512'(req_ready), 512'(2'b11));
        check("rst_resp_valid", 512'(resp_valid), 512'(0));
        check("rst_resp_data", resp_data, 512'(0));
        check("rst_addr_valid", 512'(llc_r_addr_valid), 512'(0));
        check("rst_addr", 512'(llc_r_addr), 512'(0));
        check("rst_err", 512'(err_timeout), 512'(0));
        check("rst_req_ready_b", 512'(req_ready_b), 512'(2'b11));
        check("rst_err_b", 512'(err_timeout_b), 512'(0));

        // Single transactions: hit, miss and assorted addresses/requesters.
        for (int v = 0; v < 5; v++) begin
            llc_delay = vecs[v].delay;
            issue_req(vecs[v].req, vecs[v].addr);
            exp_q.push_back('{vecs[v].req, vecs[v].addr, vecs[v].lat, vecs[v].issue});
            wait_done(100);
            check("no_timeout", 512'(err_timeout), 512'(0));
        end

        // data_valid while idle must not capture or respond.
        llc_spurious = 1'b1;
        repeat (4) tick();
        llc_spurious = 1'b0;
        tick();
        check("spurious_dv_ignored", resp_data, line_of(vecs[4].addr));

        // Contention: both requesters at once, strict alternation from rr_ptr=0.
        do_reset();
        llc_delay = 0;
        llc_txn   = 0;
        for (int r = 0; r < 4; r++) begin
            issue_req(0, 64'h40);
            issue_req(1, 64'h80);
            exp_q.push_back('{0, 64'h40, -1, 1});
            exp_q.push_back('{1, 64'h80, -1, 1});
            wait_done(50);
        end
        check("llc_txn_count", 512'(llc_txn), 512'(8));

        // Refill during own RESP loses to the other pending requester.
        do_reset();
        llc_delay = 3;
        issue_req(0, 64'h100);
        exp_q.push_back('{0, 64'h100, 5, 4});
        tick();
        tick();
        issue_req(1, 64'h200);
        exp_q.push_back('{1, 64'h200, -1, 4});
        refill_pending = 1'b1;
        refill_addr    = 64'h300;
        wait_done(100);
        check("refill_consumed", 512'(refill_pending), 512'(0));

        // Reset with a miss in flight drops it silently.
        do_reset();
        llc_delay = 50;
        issue_req(0, 64'h5000);
        tick();
        tick();
        tick();
        check("inflight_addr_valid", 512'(llc_r_addr_valid), 512'(1));
        check("inflight_addr", 512'(llc_r_addr), 512'(64'h5000));
        unexp_before = unexp_cnt;
        do_reset();
        check("midrst_req_ready", 512'(req_ready), 512'(2'b11));
        check("midrst_addr_valid", 512'(llc_r_addr_valid), 512'(0));
        check("midrst_resp_valid", 512'(resp_valid), 512'(0));
        repeat (60) tick();
        check("dropped_no_resp", 512'(unexp_cnt - unexp_before), 512'(0));

        // Timeout instance: LLC never answers. wait_cnt is 7 during ISSUE
        // cycle 8, so the flag is visible right after that cycle's closing edge.
        req_valid_b        = 2'b01;
        req_addr_b[63:0]   = 64'hABC0;
        tick();
        req_valid_b = '0;
        repeat (8) tick();
        check("to_issue_active", 512'(llc_r_addr_valid_b), 512'(1));
        check("to_before_limit", 512'(err_timeout_b), 512'(0));
        tick();
        check("to_set", 512'(err_timeout_b), 512'(1));
        repeat (20) tick();
        check("to_sticky", 512'(err_timeout_b), 512'(1));
        check("to_still_waiting", 512'(llc_r_addr_valid_b), 512'(1));
        check("to_addr_held", 512'(llc_r_addr_b), 512'(64'hABC0));
        check("to_no_resp", 512'(resp_valid_b), 512'(0));
        check("to_resp_data", resp_data_b, 512'(0));
        do_reset();
        check("to_cleared", 512'(err_timeout_b), 512'(0));
        check("to_ready_restored", 512'(req_ready_b), 512'(2'b11));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
